int_ctrl: RTL

- Interrupt controller directly downstream of the bridge-attached timers and other devices.
- Collects up to N_SRC device IRQ lines (timer IRQ on bit 0), latches them into a pending register and applies a mask.
- Presents one request plus a masked vector (HWINT_O) to CP0, then tracks the acknowledge/EOI handshake.
- Programmed through the same bridge word interface the timers use (ADD_I[3:2], WE_I, DAT_I, DAT_O).

---
 rtl/int_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller between bridge-attached devices and CP0.
// Latches up to N_SRC device requests into PEND (level or rising-edge per
// source), masks them, raises one request to CP0 and tracks ACK/EOI.
// Register map (word select ADD_I): 00 PEND (W1C, edge bits only),
// 01 MASK, 10 MODE (1 = rising edge), 11 STAT (read) / EOI (any write).
// Optional build macro: INTC_SYNC_EN adds a two-flop input synchronizer.
//
// state   | meaning
// IDLE    | no request outstanding
// REQ     | IRQ_O high, waiting for INT_ACK; id follows current priority
// SERVICE | ack taken, ISR running, waiting for EOI write to STAT
module int_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [1:0]       ADD_I,
    input  logic             WE_I,
    input  logic [31:0]      DAT_I,
    output logic [31:0]      DAT_O,
    input  logic [N_SRC-1:0] IRQ_SRC,
    input  logic             INT_ACK,
    output logic             IRQ_O,
    output logic [N_SRC-1:0] HWINT_O
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } state_t;

    state_t           state;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] src_prev;
    logic [N_SRC-1:0] src;
    logic [4:0]       isr_id;
    logic             isr_valid;

    logic [N_SRC-1:0] active;
    logic             req_valid;
    logic [4:0]       req_id;
    logic             ack_take;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] edge_set;
    logic [N_SRC-1:0] edge_clr;
    logic [N_SRC-1:0] pend_nxt;
    logic             wr_pend;
    logic             wr_mask;
    logic             wr_mode;
    logic             wr_eoi;
    logic [N_SRC-1:0] wdata;

`ifdef INTC_SYNC_EN
    logic [N_SRC-1:0] sync_1;
    logic [N_SRC-1:0] sync_2;

    // Two-flop synchronizer for asynchronous device request lines.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= IRQ_SRC;
            sync_2 <= sync_1;
        end
    end

    assign src = sync_2;
`else
    assign src = IRQ_SRC;
`endif

    // Upper write-data bits have no destination.
    logic unused_dat;
    if (N_SRC < 32) begin : g_unused
        assign unused_dat = ^DAT_I[31:N_SRC];
    end else begin : g_no_unused
        assign unused_dat = 1'b0;
    end

    assign wdata   = DAT_I[N_SRC-1:0];
    assign wr_pend = WE_I && (ADD_I == 2'b00);
    assign wr_mask = WE_I && (ADD_I == 2'b01);
    assign wr_mode = WE_I && (ADD_I == 2'b10);
    assign wr_eoi  = WE_I && (ADD_I == 2'b11);

    // Lowest-index enabled pending source wins.
    always_comb begin
        active    = pend & mask;
        req_valid = |active;
        req_id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) req_id = 5'(i);
        end
    end

    // Pending next-state: level bits follow the source, edge bits latch
    // rising edges and are cleared by W1C or by the ack of that id; a new
    // edge in the same cycle as a clear keeps the bit set.
    always_comb begin
        ack_take = (state == REQ) && INT_ACK;
        for (int i = 0; i < N_SRC; i++) begin
            ack_clr[i] = ack_take && req_valid && (req_id == 5'(i));
        end
        w1c      = wr_pend ? wdata : '0;
        edge_set = src & ~src_prev & mode;
        edge_clr = (w1c | ack_clr) & mode;
        pend_nxt = (~mode & src) | edge_set | (mode & pend & ~edge_clr);
    end

    // Pending, mask, mode and edge-detect history.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            pend     <= '0;
            mask     <= '0;
            mode     <= '0;
            src_prev <= '0;
        end else begin
            pend     <= pend_nxt;
            src_prev <= src;
            if (wr_mask) mask <= wdata;
            if (wr_mode) mode <= wdata;
        end
    end

    // Request / acknowledge / EOI sequencing.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state     <= IDLE;
            isr_id    <= '0;
            isr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state  <= REQ;
                        isr_id <= req_id;
                    end
                end
                REQ: begin
                    if (INT_ACK) begin
                        state     <= SERVICE;
                        isr_id    <= req_id;
                        isr_valid <= 1'b1;
                    end else if (!req_valid) begin
                        state <= IDLE;
                    end else begin
                        isr_id <= req_id;
                    end
                end
                SERVICE: begin
                    if (wr_eoi) begin
                        state     <= IDLE;
                        isr_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    isr_valid <= 1'b0;
                end
            endcase
        end
    end

    // Register readback.
    always_comb begin
        DAT_O = '0;
        case (ADD_I)
            2'b00:   DAT_O[N_SRC-1:0] = pend;
            2'b01:   DAT_O[N_SRC-1:0] = mask;
            2'b10:   DAT_O[N_SRC-1:0] = mode;
            default: DAT_O = {isr_valid, 21'b0, state, 3'b0, isr_id};
        endcase
    end

    assign IRQ_O   = (state == REQ);
    assign HWINT_O = pend & mask;

endmodule
